// File: rtl/comp_serial_ctrl.sv
// comp_serial_ctrl: bit-serial magnitude comparator controller.
// Latches two operands on start, walks them MSB first through a single
// 1-bit compare, stops on the first differing bit and presents a one-hot
// greater/equal/less result with a one-cycle done pulse.
module comp_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l,
    output logic [CW-1:0]    bits_used
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic [IW-1:0]    idx_r, idx_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic [CW-1:0]    cnt_inc_s;
    logic             g_r, g_nxt_s;
    logic             e_r, e_nxt_s;
    logic             l_r, l_nxt_s;
    logic [CW-1:0]    bits_r, bits_nxt_s;
    logic             done_r, done_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             a_bit_s, b_bit_s;

    assign a_bit_s   = a_r[idx_r];
    assign b_bit_s   = b_r[idx_r];
    assign cnt_inc_s = cnt_r + CW'(1);

    // Next-state and next-output logic; every register holds unless a case below updates it.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        g_nxt_s     = g_r;
        e_nxt_s     = e_r;
        l_nxt_s     = l_r;
        bits_nxt_s  = bits_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_nxt_s     = a;
                    b_nxt_s     = b;
                    idx_nxt_s   = IW'(WIDTH - 1);
                    cnt_nxt_s   = {CW{1'b0}};
                    g_nxt_s     = 1'b0;
                    e_nxt_s     = 1'b0;
                    l_nxt_s     = 1'b0;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                cnt_nxt_s = cnt_inc_s;
                case ({a_bit_s, b_bit_s})
                    2'b10: begin
                        g_nxt_s     = 1'b1;
                        bits_nxt_s  = cnt_inc_s;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = DONE;
                    end
                    2'b01: begin
                        l_nxt_s     = 1'b1;
                        bits_nxt_s  = cnt_inc_s;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = DONE;
                    end
                    default: begin
                        // Bits agree: finish as equal at the LSB, otherwise step down.
                        if (idx_r == IW'(0)) begin
                            e_nxt_s     = 1'b1;
                            bits_nxt_s  = cnt_inc_s;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = DONE;
                        end else begin
                            idx_nxt_s   = idx_r - IW'(1);
                        end
                    end
                endcase
            end
            DONE: begin
                // start is deliberately ignored here; the next accept happens from IDLE.
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {IW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            g_r     <= 1'b0;
            e_r     <= 1'b0;
            l_r     <= 1'b0;
            bits_r  <= {CW{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            g_r     <= g_nxt_s;
            e_r     <= e_nxt_s;
            l_r     <= l_nxt_s;
            bits_r  <= bits_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign g         = g_r;
    assign e         = e_r;
    assign l         = l_r;
    assign bits_used = bits_r;

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Self-checking bench for comp_serial_ctrl (WIDTH=8): table-driven compares
// through an expected-result queue, plus hand sequences for the multi-cycle
// corner cases (ignored start, mid-RUN reset, back-to-back compares).
module tb_comp_serial_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             l;
    logic [CW-1:0]    bits_used;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] glr;
        int         bits;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];
    int   checks;
    int   errors;

    comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .g         (g),
        .e         (e),
        .l         (l),
        .bits_used (bits_used)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: walk from the MSB, stop on the first differing bit.
    function automatic vec_t model(input logic [7:0] va, input logic [7:0] vb);
        vec_t r;
        r.a    = va;
        r.b    = vb;
        r.glr  = 3'b010;
        r.bits = 0;
        for (int i = 7; i >= 0; i--) begin
            r.bits++;
            if (va[i] != vb[i]) begin
                r.glr = va[i] ? 3'b100 : 3'b001;
                break;
            end
        end
        return r;
    endfunction

    // One full compare: push expectation, pulse start, wait for done, pop and compare.
    task automatic do_compare(input vec_t v);
        vec_t ex;
        int   cyc;
        @(negedge clk);
        a = v.a;
        b = v.b;
        start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        a = ~v.a;
        b = ~v.b;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("glr_cleared", {29'd0, g, e, l}, 32'd0);
        cyc = 0;
        while (!done && cyc < WIDTH + 4) begin
            @(negedge clk);
            cyc++;
            if (!done) chk("glr_zero_in_run", {29'd0, g, e, l}, 32'd0);
        end
        ex = exp_q.pop_front();
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("glr", {29'd0, g, e, l}, {29'd0, ex.glr});
            chk("bits_used", {28'd0, bits_used}, ex.bits);
            chk("latency", cyc, ex.bits);
            chk("busy_in_done", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("busy_idle", {31'd0, busy}, 32'd0);
            chk("result_hold", {29'd0, g, e, l}, {29'd0, ex.glr});
        end
    endtask

    initial begin
        vec_t v;
        int   cyc;
        int   ndone;
        int   pos[$];

        checks = 0;
        errors = 0;
        vecs[0] = '{8'hA5, 8'h25, 3'b100, 1};
        vecs[1] = '{8'h3C, 8'h3C, 3'b010, 8};
        vecs[2] = '{8'h10, 8'h11, 3'b001, 8};
        vecs[3] = '{8'h80, 8'h7F, 3'b100, 1};
        vecs[4] = '{8'h00, 8'h00, 3'b010, 8};
        vecs[5] = '{8'hFF, 8'hFE, 3'b100, 8};
        vecs[6] = '{8'h12, 8'h34, 3'b001, 3};
        vecs[7] = '{8'h00, 8'hFF, 3'b001, 1};

        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_glr", {29'd0, g, e, l}, 32'd0);
        chk("rst_bits", {28'd0, bits_used}, 32'd0);
        rst = 1'b0;

        // Table-driven compares.
        for (int i = 0; i < 8; i++) do_compare(vecs[i]);

        // Random compares against the reference model.
        for (int i = 0; i < 6; i++) begin
            v = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            do_compare(v);
        end

        // start and operand changes during RUN are ignored; start in DONE is not accepted.
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        cyc = 0;
        while (!done && cyc < WIDTH + 4) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_done_seen", {31'd0, done}, 32'd1);
        chk("ign_glr", {29'd0, g, e, l}, 32'b010);
        chk("ign_bits", {28'd0, bits_used}, 32'd8);
        chk("ign_latency", cyc, 32'd8);
        @(negedge clk);
        start = 1'b0;
        chk("done_start_not_accepted", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("still_idle", {31'd0, busy}, 32'd0);
        chk("still_holds", {29'd0, g, e, l}, 32'b010);

        // Reset on the 3rd RUN cycle aborts the compare with no done pulse.
        @(negedge clk);
        a = 8'h0F;
        b = 8'h0E;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_glr", {29'd0, g, e, l}, 32'd0);
        chk("abort_bits", {28'd0, bits_used}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_activity", ndone, 32'd0);
        do_compare(model(8'h0F, 8'h0E));

        // start held high: back-to-back compares, one done every 3 cycles.
        @(negedge clk);
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            if (done) begin
                pos.push_back(t);
                chk("b2b_glr", {29'd0, g, e, l}, 32'b001);
                chk("b2b_bits", {28'd0, bits_used}, 32'd1);
            end
            if (t == 8) start = 1'b0;
        end
        chk("b2b_count", pos.size(), 32'd3);
        if (pos.size() == 3) begin
            chk("b2b_first", pos[0], 32'd1);
            chk("b2b_gap1", pos[1] - pos[0], 32'd3);
            chk("b2b_gap2", pos[2] - pos[1], 32'd3);
        end
        repeat (3) @(negedge clk);
        chk("b2b_stopped", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
